// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Counter must hold 0..width, hence log2 of width+1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level single-bit full subtractor: D = X - Y - Bi with borrow out Bo.
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  logic w_xy;

  assign w_xy = X ^ Y;
  assign D    = w_xy ^ Bi;
  assign Bo   = (~X & Y) | (~w_xy & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - Bin, LSB first, one bit per clock, with
// a start/busy/done handshake. Results hold until the next completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             Bout,
  output logic             OVF
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CntW-1:0]  r_cnt;
  logic             r_borrow;
  logic             r_done;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_fs (
    .X  (r_a[0]),
    .Y  (r_b[0]),
    .Bi (r_borrow),
    .D  (w_d),
    .Bo (w_bo)
  );

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_d;
    end else begin : g_res_wn
      assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  assign w_accept = (r_state == StIdle) && start;
  assign w_run    = (r_state == StRun);
  assign w_last   = w_run && (r_cnt == LastCnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (start) w_state_next = StRun;
      StRun:  if (r_cnt == LastCnt) w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= A;
        r_b      <= B;
        r_borrow <= Bin;
        r_res    <= '0;
        r_cnt    <= '0;
      end else if (w_run) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_borrow <= w_bo;
        r_res    <= w_res_next;
        r_cnt    <= r_cnt + CntW'(1);
        if (w_last) begin
          r_diff <= w_res_next;
          r_bout <= w_bo;
          // On the MSB edge r_borrow is exactly the borrow into the MSB (Bin when WIDTH=1).
          r_ovf  <= r_borrow ^ w_bo;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = w_run;
  assign done = r_done;
  assign DIFF = r_diff;
  assign Bout = r_bout;
  assign OVF  = r_ovf;

endmodule
